uart_rx_conditioner: RTL and testbench
======================================

// Module: uart_rx_conditioner
// PURPOSE
//  Front end for the UART receive pin; sits directly upstream of the UART RX input, in the Clk_14MHz (baud) domain.
//  Synchronises and majority-filters the raw pin, then drives the filtered line into the UART.
//  Provides autobaud: measures one 0x55 calibration character and produces a divisor for the UART DLR register.
//  The divisor follows the UART convention: bit period = 2*DLR clocks.
// PARAMETERS
//  SYNC_STAGES  2        synchroniser flops on RxPin (>=2)
//  FILT_LEN     3        majority window length (odd, 3..7)
//  CNT_W        20       autobaud period counter width
//  DIV_RST      16'd729  AbDiv reset value (9600 baud at 14 MHz)
// PORTS
//  Clk       in   1   baud-domain clock
//  Rst       in   1   synchronous, active-high reset
//  RxPin     in   1   raw asynchronous RX pin
//  RxOut     out  1   filtered line to UART RX
//  AbStart   in   1   1-cycle pulse: arm autobaud
//  AbCancel  in   1   1-cycle pulse: abort autobaud
//  AbBusy    out  1   autobaud armed or measuring
//  AbDone    out  1   1-cycle pulse: AbDiv updated
//  AbErr     out  1   1-cycle pulse: measurement rejected
//  AbDiv     out  16  last good divisor
//  BreakDet  out  1   break level (UART_BREAK_DET_EN only, else tied 0)
// BEHAVIOUR
//  Reset values: sync chain and filter window all 1; RxOut=1; AbBusy=0; AbDone=0; AbErr=0; AbDiv=DIV_RST; BreakDet=0; FSM=AB_IDLE.
//  Filter:
//   - rx_f <= majority(window) each cycle.
//   - Pin-to-rx_f latency is SYNC_STAGES+(FILT_LEN+1)/2 cycles.
//   - Pulses shorter than (FILT_LEN+1)/2 cycles are suppressed.
//  Edge detect: fall = rx_f_d & !rx_f; rise = !rx_f_d & rx_f.
//  RxOut = rx_f when AbBusy=0. RxOut = 1 while AbBusy=1, so the UART never sees the calibration character.
//  FSM:
//   - AB_IDLE: AbStart -> AB_WAIT.
//   - AB_WAIT: on fall -> AB_MEAS; T=1, W0=0, nfall=1.
//   - AB_MEAS:
//     - T increments each cycle, saturating at 2^CNT_W-1.
//     - On the first rise, W0<=T (start-bit low width).
//     - Each fall increments nfall. At the 5th fall -> AB_CALC (0x55 gives 5 falls spanning 8 bit times).
//     - If T saturates -> AB_IDLE with an AbErr pulse.
//   - AB_CALC (1 cycle): D=(T+8)>>4.
//     - Error if D==0, D>16'hFFFF, or |8*W0 - T| > T>>2.
//     - Error -> AbErr pulse, AbDiv unchanged.
//     - Pass -> AbDiv<=D[15:0].
//     - Either way -> AB_DRAIN.
//   - AB_DRAIN: wait for rise (stop bit). On rise -> AB_IDLE; AbDone pulses that cycle if AB_CALC passed.
//  AbBusy=1 in every state except AB_IDLE.
//  AbStart is ignored while AbBusy=1.
//  AbCancel in any busy state -> AB_IDLE next cycle with no AbDone/AbErr; AbDiv unchanged.
//  AbCancel wins over a simultaneous AbStart.
//  Rst mid-measurement restores all reset values, including AbDiv=DIV_RST.
//  AbDone and AbErr are never asserted in the same cycle.
// CONFIGURATION
//  UART_BREAK_DET_EN defined:
//   - A low counter runs while rx_f=0, saturating.
//   - BreakDet=1 once the count reaches 20*AbDiv (10 bit times).
//   - Clears on the cycle after rx_f rises.
//   - The counter is 22 bits wide.
//  UART_BREAK_DET_EN undefined: BreakDet tied 0; no counter logic.
// TESTING
//  1. FILT_LEN=3: 1-cycle low on RxPin -> RxOut stays 1. 4-cycle low -> RxOut low 4 cycles after the pin falls.
//  2. AbStart, then 0x55 at 1458 clk/bit -> AbDone after the stop-bit edge; AbDiv=729; RxOut=1 throughout; AbErr=0.
//  3. AbStart, 0x55 at 208 clk/bit -> AbDiv=104. Then 0x55 at 1458 clk/bit with no AbStart -> normal RxOut passthrough, AbDiv stays 104.
//  4. AbStart, first low 2916 clk then pattern giving T=11664 -> AbErr pulse; AbDiv unchanged.
//  5. AbStart, fall, AbCancel after 500 clk -> AbBusy=0 next cycle; no AbDone/AbErr; RxOut follows pin again.
//  6. UART_BREAK_DET_EN, AbDiv=729, pin low 20000 clk -> BreakDet rises 14580 clk after the rx_f fall; clears after release.

Source files
------------

// File: rtl/uart_rx_conditioner_if.sv
// rtl/uart_rx_conditioner_if.sv - signal bundle between the UART RX pin conditioner and its host
//
// Signals (master = host / pin side, slave = conditioner):
//   RxPin     master->slave  raw asynchronous RX pin
//   RxOut     slave->master  filtered line to the UART RX input
//   AbStart   master->slave  1-cycle pulse: arm autobaud
//   AbCancel  master->slave  1-cycle pulse: abort autobaud
//   AbBusy    slave->master  autobaud armed or measuring
//   AbDone    slave->master  1-cycle pulse: AbDiv updated
//   AbErr     slave->master  1-cycle pulse: measurement rejected
//   AbDiv     slave->master  last good divisor (bit period = 2*AbDiv clocks)
//   BreakDet  slave->master  break level (0 unless break detection is built in)
interface uart_rx_conditioner_if;
  logic        RxPin;
  logic        RxOut;
  logic        AbStart;
  logic        AbCancel;
  logic        AbBusy;
  logic        AbDone;
  logic        AbErr;
  logic [15:0] AbDiv;
  logic        BreakDet;

  modport master (
    output RxPin, AbStart, AbCancel,
    input  RxOut, AbBusy, AbDone, AbErr, AbDiv, BreakDet
  );

  modport slave (
    input  RxPin, AbStart, AbCancel,
    output RxOut, AbBusy, AbDone, AbErr, AbDiv, BreakDet
  );
endinterface

// File: rtl/uart_rx_conditioner.sv
// rtl/uart_rx_conditioner.sv - UART RX pin synchroniser, majority filter and autobaud measurement
//
// Ports:
//   Clk   baud-domain clock
//   Rst   synchronous, active-high reset
//   bus   uart_rx_conditioner_if.slave (RxPin, RxOut, AbStart, AbCancel,
//         AbBusy, AbDone, AbErr, AbDiv, BreakDet)
//
// Parameters:
//   SYNC_STAGES  synchroniser flops on RxPin (>=2)
//   FILT_LEN     majority window length (odd, 3..7)
//   CNT_W        autobaud period counter width (>=15)
//   DIV_RST      AbDiv reset value
//
// Build option: define UART_BREAK_DET_EN to include the break detector;
// otherwise BreakDet is tied low.
module uart_rx_conditioner #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 3,
  parameter int          CNT_W       = 20,
  parameter logic [15:0] DIV_RST     = 16'd729
) (
  input logic             Clk,
  input logic             Rst,
  uart_rx_conditioner_if.slave bus
);

  localparam int HALF = (FILT_LEN + 1) / 2;
  localparam logic [CNT_W-1:0] T_MAX = '1;

  typedef enum logic [2:0] {
    AB_IDLE,
    AB_WAIT,
    AB_MEAS,
    AB_CALC,
    AB_DRAIN
  } ab_state_t;

  // ------------------------------------------------------------------
  // Synchroniser and majority filter
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-2:0]    hist_q;
  logic [FILT_LEN-1:0]    window;
  logic                   rx_f;
  logic                   rx_f_d;
  logic                   maj;
  logic                   fall;
  logic                   rise;

  // The newest window sample is the synchroniser output itself, so only
  // FILT_LEN-1 history flops are needed and the filter adds HALF cycles.
  assign window = {hist_q, sync_q[SYNC_STAGES-1]};

  always_comb begin
    int ones;
    ones = 0;
    for (int i = 0; i < FILT_LEN; i++) begin
      ones = ones + int'(window[i]);
    end
    maj = (ones >= HALF);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= '1;
      hist_q <= '1;
      rx_f   <= 1'b1;
      rx_f_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RxPin};
      hist_q <= {hist_q[FILT_LEN-3:0], sync_q[SYNC_STAGES-1]};
      rx_f   <= maj;
      rx_f_d <= rx_f;
    end
  end

  assign fall = rx_f_d & ~rx_f;
  assign rise = ~rx_f_d & rx_f;

  // ------------------------------------------------------------------
  // Autobaud measurement
  // ------------------------------------------------------------------
  ab_state_t        state_q;
  logic [CNT_W-1:0] t_q;
  logic [CNT_W-1:0] w0_q;
  logic [2:0]       nfall_q;
  logic             got_rise_q;
  logic             pass_q;
  logic             ab_busy_q;
  logic             ab_done_q;
  logic             ab_err_q;
  logic [15:0]      ab_div_q;

  // Divisor rounds T/16: 0x55 spans 8 bit times = 16*DLR clocks.
  logic [CNT_W:0]   div_full;
  logic [CNT_W+2:0] w0_x8;
  logic [CNT_W+2:0] t_ext;
  logic [CNT_W+2:0] w0_diff;
  logic             calc_bad;

  assign div_full = ({1'b0, t_q} + (CNT_W+1)'(8)) >> 4;
  assign w0_x8    = {w0_q, 3'b000};
  assign t_ext    = (CNT_W+3)'(t_q);
  assign w0_diff  = (w0_x8 > t_ext) ? (w0_x8 - t_ext) : (t_ext - w0_x8);
  // The start-bit width predicts T/8; a wrong character disagrees by >25%.
  assign calc_bad = (div_full == '0)
                 || (div_full > (CNT_W+1)'(16'hFFFF))
                 || (w0_diff > (t_ext >> 2));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= AB_IDLE;
      t_q        <= '0;
      w0_q       <= '0;
      nfall_q    <= '0;
      got_rise_q <= 1'b0;
      pass_q     <= 1'b0;
      ab_busy_q  <= 1'b0;
      ab_done_q  <= 1'b0;
      ab_err_q   <= 1'b0;
      ab_div_q   <= DIV_RST;
    end else begin
      ab_done_q <= 1'b0;
      ab_err_q  <= 1'b0;
      if (state_q != AB_IDLE && bus.AbCancel) begin
        state_q   <= AB_IDLE;
        ab_busy_q <= 1'b0;
      end else begin
        case (state_q)
          AB_IDLE: begin
            if (bus.AbStart && !bus.AbCancel) begin
              state_q   <= AB_WAIT;
              ab_busy_q <= 1'b1;
            end
          end
          AB_WAIT: begin
            if (fall) begin
              state_q    <= AB_MEAS;
              t_q        <= CNT_W'(1);
              w0_q       <= '0;
              nfall_q    <= 3'd1;
              got_rise_q <= 1'b0;
            end
          end
          AB_MEAS: begin
            if (t_q == T_MAX) begin
              state_q   <= AB_IDLE;
              ab_busy_q <= 1'b0;
              ab_err_q  <= 1'b1;
            end else begin
              t_q <= t_q + CNT_W'(1);
              if (rise && !got_rise_q) begin
                w0_q       <= t_q;
                got_rise_q <= 1'b1;
              end
              if (fall) begin
                nfall_q <= nfall_q + 3'd1;
                if (nfall_q == 3'd4) begin
                  state_q <= AB_CALC;
                end
              end
            end
          end
          AB_CALC: begin
            if (calc_bad) begin
              ab_err_q <= 1'b1;
              pass_q   <= 1'b0;
            end else begin
              ab_div_q <= div_full[15:0];
              pass_q   <= 1'b1;
            end
            state_q <= AB_DRAIN;
          end
          AB_DRAIN: begin
            if (rise) begin
              state_q   <= AB_IDLE;
              ab_busy_q <= 1'b0;
              ab_done_q <= pass_q;
            end
          end
          default: begin
            state_q   <= AB_IDLE;
            ab_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // The UART must never see the calibration character.
  assign bus.RxOut  = rx_f | ab_busy_q;
  assign bus.AbBusy = ab_busy_q;
  assign bus.AbDone = ab_done_q;
  assign bus.AbErr  = ab_err_q;
  assign bus.AbDiv  = ab_div_q;

  // ------------------------------------------------------------------
  // Break detection: line held low for 10 bit times = 20*AbDiv clocks
  // ------------------------------------------------------------------
`ifdef UART_BREAK_DET_EN
  logic [21:0] low_cnt_q;
  logic [21:0] brk_thr;
  logic        break_q;

  assign brk_thr = {6'b0, ab_div_q} * 22'd20;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      low_cnt_q <= '0;
      break_q   <= 1'b0;
    end else if (rx_f) begin
      low_cnt_q <= '0;
      break_q   <= 1'b0;
    end else begin
      if (low_cnt_q != '1) begin
        low_cnt_q <= low_cnt_q + 22'd1;
      end
      // Compare against the post-increment count so BreakDet rises
      // exactly 20*AbDiv cycles after rx_f falls.
      if (low_cnt_q >= brk_thr - 22'd1) begin
        break_q <= 1'b1;
      end
    end
  end

  assign bus.BreakDet = break_q;
`else
  assign bus.BreakDet = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// tb/tb_uart_rx_conditioner.sv - directed self-checking bench for uart_rx_conditioner
module tb_uart_rx_conditioner;

  logic Clk;
  logic Rst;
  uart_rx_conditioner_if intf ();

  uart_rx_conditioner dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (intf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int errors;
  int done_cnt;
  int err_cnt;
  int both_cnt;
  int rxlow_cnt;

  initial begin
    done_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    rxlow_cnt = 0;
  end

  always @(negedge Clk) begin
    if (intf.AbDone === 1'b1) done_cnt++;
    if (intf.AbErr === 1'b1) err_cnt++;
    if (intf.AbDone === 1'b1 && intf.AbErr === 1'b1) both_cnt++;
    if (intf.RxOut === 1'b0) rxlow_cnt++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    intf.RxPin = 1'b0;
    ticks(n);
    for (int i = 0; i < 8; i++) begin
      intf.RxPin = v[i];
      ticks(n);
    end
    intf.RxPin = 1'b1;
    ticks(n);
  endtask

  task automatic pulse_start();
    intf.AbStart = 1'b1;
    tick();
    intf.AbStart = 1'b0;
  endtask

  int d0, e0, l0;
  int first_hit;
  logic seen_low;

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    intf.RxPin = 1'b1;
    intf.AbStart = 1'b0;
    intf.AbCancel = 1'b0;
    ticks(3);
    Rst = 1'b0;

    // Reset state
    check("rst_rxout", 32'(intf.RxOut), 32'd1);
    check("rst_busy", 32'(intf.AbBusy), 32'd0);
    check("rst_done", 32'(intf.AbDone), 32'd0);
    check("rst_err", 32'(intf.AbErr), 32'd0);
    check("rst_div", 32'(intf.AbDiv), 32'd729);
    check("rst_break", 32'(intf.BreakDet), 32'd0);
    ticks(5);

    // Filter: 1-cycle glitch suppressed
    intf.RxPin = 1'b0;
    tick();
    intf.RxPin = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (intf.RxOut !== 1'b1) seen_low = 1'b1;
    end
    check("glitch_suppressed", 32'(seen_low), 32'd0);

    // Filter: 4-cycle low passes with 4-cycle latency
    intf.RxPin = 1'b0;
    ticks(3);
    check("lat_before", 32'(intf.RxOut), 32'd1);
    tick();
    intf.RxPin = 1'b1;
    check("lat_at4", 32'(intf.RxOut), 32'd0);
    ticks(3);
    check("low_width_end", 32'(intf.RxOut), 32'd0);
    tick();
    check("low_width_rel", 32'(intf.RxOut), 32'd1);
    ticks(5);

    // Autobaud at 208 clk/bit -> 104
    d0 = done_cnt; e0 = err_cnt; l0 = rxlow_cnt;
    pulse_start();
    check("busy_after_start", 32'(intf.AbBusy), 32'd1);
    send_byte(8'h55, 208);
    ticks(10);
    check("ab208_div", 32'(intf.AbDiv), 32'd104);
    check("ab208_done", 32'(done_cnt - d0), 32'd1);
    check("ab208_err", 32'(err_cnt - e0), 32'd0);
    check("ab208_rxout_high", 32'(rxlow_cnt - l0), 32'd0);
    check("ab208_busy_end", 32'(intf.AbBusy), 32'd0);

    // 0x55 at 1458 without AbStart: passthrough, divisor unchanged
    d0 = done_cnt; l0 = rxlow_cnt;
    send_byte(8'h55, 1458);
    ticks(10);
    check("pass_low_cycles", 32'(rxlow_cnt - l0), 32'd7290);
    check("pass_div", 32'(intf.AbDiv), 32'd104);
    check("pass_no_done", 32'(done_cnt - d0), 32'd0);

    // Autobaud at 1458 clk/bit -> 729
    d0 = done_cnt; e0 = err_cnt; l0 = rxlow_cnt;
    pulse_start();
    send_byte(8'h55, 1458);
    ticks(10);
    check("ab1458_div", 32'(intf.AbDiv), 32'd729);
    check("ab1458_done", 32'(done_cnt - d0), 32'd1);
    check("ab1458_err", 32'(err_cnt - e0), 32'd0);
    check("ab1458_rxout_high", 32'(rxlow_cnt - l0), 32'd0);

    // Bad start-bit width: W0=2916, T=11664 -> rejected
    d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    intf.RxPin = 1'b0; ticks(2916);
    intf.RxPin = 1'b1; ticks(1458);
    intf.RxPin = 1'b0; ticks(1000);
    intf.RxPin = 1'b1; ticks(626);
    intf.RxPin = 1'b0; ticks(1000);
    intf.RxPin = 1'b1; ticks(1000);
    intf.RxPin = 1'b0; ticks(1000);
    intf.RxPin = 1'b1; ticks(2663);
    intf.RxPin = 1'b0; ticks(1000);
    intf.RxPin = 1'b1; ticks(50);
    check("bad_err", 32'(err_cnt - e0), 32'd1);
    check("bad_no_done", 32'(done_cnt - d0), 32'd0);
    check("bad_div", 32'(intf.AbDiv), 32'd729);
    check("bad_busy_end", 32'(intf.AbBusy), 32'd0);

    // Cancel mid-measurement
    d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    intf.RxPin = 1'b0;
    ticks(500);
    check("cancel_busy_before", 32'(intf.AbBusy), 32'd1);
    intf.AbCancel = 1'b1;
    tick();
    intf.AbCancel = 1'b0;
    check("cancel_busy", 32'(intf.AbBusy), 32'd0);
    check("cancel_rx_follows", 32'(intf.RxOut), 32'd0);
    intf.RxPin = 1'b1;
    ticks(10);
    check("cancel_rx_high", 32'(intf.RxOut), 32'd1);
    check("cancel_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("cancel_div", 32'(intf.AbDiv), 32'd729);

    // Cancel wins over simultaneous start
    intf.AbStart = 1'b1;
    intf.AbCancel = 1'b1;
    tick();
    intf.AbStart = 1'b0;
    intf.AbCancel = 1'b0;
    check("cancel_beats_start", 32'(intf.AbBusy), 32'd0);

    // Reset mid-measurement restores AbDiv
    pulse_start();
    send_byte(8'h55, 208);
    ticks(10);
    check("pre_rst_div", 32'(intf.AbDiv), 32'd104);
    pulse_start();
    intf.RxPin = 1'b0;
    ticks(300);
    Rst = 1'b1;
    intf.RxPin = 1'b1;
    tick();
    Rst = 1'b0;
    check("midrst_div", 32'(intf.AbDiv), 32'd729);
    check("midrst_busy", 32'(intf.AbBusy), 32'd0);
    check("midrst_rxout", 32'(intf.RxOut), 32'd1);
    ticks(5);

`ifdef UART_BREAK_DET_EN
    // Break: AbDiv=729 -> BreakDet 14580 clk after rx_f falls (pin + 4)
    first_hit = 0;
    intf.RxPin = 1'b0;
    for (int i = 1; i <= 20000; i++) begin
      tick();
      if (first_hit == 0 && intf.BreakDet === 1'b1) first_hit = i;
    end
    check("break_rise_time", 32'(first_hit), 32'd14584);
    intf.RxPin = 1'b1;
    ticks(4);
    check("break_hold", 32'(intf.BreakDet), 32'd1);
    tick();
    check("break_clear", 32'(intf.BreakDet), 32'd0);
`else
    intf.RxPin = 1'b0;
    ticks(200);
    check("break_tied_low", 32'(intf.BreakDet), 32'd0);
    intf.RxPin = 1'b1;
    ticks(10);
`endif

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
